// File: rtl/moving_block_renderer.sv
// Solid-rectangle VGA renderer over a background colour; the block moves once every
// FRAME_DIV frames, either steered by buttons or bouncing off the visible-area edges.
module moving_block_renderer #(
  parameter int unsigned HALF_W    = 150,
  parameter int unsigned HALF_H    = 90,
  parameter int unsigned X_MIN     = 144,
  parameter int unsigned X_MAX     = 783,
  parameter int unsigned Y_MIN     = 35,
  parameter int unsigned Y_MAX     = 514,
  parameter int unsigned X_INIT    = 450,
  parameter int unsigned Y_INIT    = 250,
  parameter int unsigned STEP      = 2,
  parameter int unsigned FRAME_DIV = 1,
  parameter logic [11:0] FG        = 12'h0F0,
  parameter logic [11:0] BG        = 12'hFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bright,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  input  logic        mode,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  output logic [11:0] rgb,
  output logic [9:0]  xpos,
  output logic [9:0]  ypos,
  output logic        move_tick
);

  localparam logic [9:0]  LX       = 10'(X_MIN + HALF_W);
  localparam logic [9:0]  HX       = 10'(X_MAX - HALF_W);
  localparam logic [9:0]  LY       = 10'(Y_MIN + HALF_H);
  localparam logic [9:0]  HY       = 10'(Y_MAX - HALF_H);
  localparam logic [10:0] STEP_W   = 11'(STEP);
  localparam logic [9:0]  STEP_N   = 10'(STEP);
  localparam logic [10:0] HALF_W_W = 11'(HALF_W);
  localparam logic [10:0] HALF_H_W = 11'(HALF_H);
  localparam int unsigned CW       = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_DIV - 1);

  // Returns {dir, pos}; clip tests are done in 11 bits so neither edge can wrap.
  function automatic logic [10:0] step_axis(input logic [9:0] p, input logic [9:0] lo,
                                            input logic [9:0] hi, input logic auto_m,
                                            input logic dir_pos, input logic inc,
                                            input logic dec);
    logic       up_clip;
    logic       dn_clip;
    logic [9:0] up_v;
    logic [9:0] dn_v;
    up_clip = ({1'b0, p} + STEP_W) > {1'b0, hi};
    dn_clip = {1'b0, p} < ({1'b0, lo} + STEP_W);
    up_v    = up_clip ? hi : p + STEP_N;
    dn_v    = dn_clip ? lo : p - STEP_N;
    if (auto_m) begin
      if (dir_pos) return {~up_clip, up_v};
      else         return {dn_clip, dn_v};
    end else if (inc && !dec) begin
      return {dir_pos, up_v};
    end else if (dec && !inc) begin
      return {dir_pos, dn_v};
    end
    return {dir_pos, p};
  endfunction

  logic          sof_prev;
  logic          sof_cond;
  logic          sof;
  logic          tick;
  logic          fill;
  logic          dir_x;
  logic          dir_y;
  logic [CW-1:0] frame_cnt;
  logic [10:0]   nxt_x;
  logic [10:0]   nxt_y;

  always_comb begin
    sof_cond = (hCount == '0) && (vCount == '0);
    sof      = sof_cond && !sof_prev;
    tick     = sof && (frame_cnt == CNT_LAST);
    nxt_x    = step_axis(xpos, LX, HX, mode, dir_x, btn_right, btn_left);
    nxt_y    = step_axis(ypos, LY, HY, mode, dir_y, btn_down, btn_up);
    fill     = (({1'b0, hCount} + HALF_W_W) >= {1'b0, xpos}) &&
               ({1'b0, hCount} <= ({1'b0, xpos} + HALF_W_W)) &&
               (({1'b0, vCount} + HALF_H_W) >= {1'b0, ypos}) &&
               ({1'b0, vCount} <= ({1'b0, ypos} + HALF_H_W));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      xpos      <= 10'(X_INIT);
      ypos      <= 10'(Y_INIT);
      dir_x     <= 1'b1;
      dir_y     <= 1'b1;
      frame_cnt <= '0;
      sof_prev  <= 1'b0;
      move_tick <= 1'b0;
      rgb       <= '0;
    end else begin
      sof_prev  <= sof_cond;
      move_tick <= tick;
      if (sof) frame_cnt <= tick ? '0 : frame_cnt + 1'b1;
      if (tick) begin
        xpos  <= nxt_x[9:0];
        dir_x <= nxt_x[10];
        ypos  <= nxt_y[9:0];
        dir_y <= nxt_y[10];
      end
      rgb <= !bright ? 12'h000 : (fill ? FG : BG);
    end
  end

endmodule

// File: tb/tb_moving_block_renderer.sv
// Bench for moving_block_renderer: render table, SOF/divider, clamp, bounce, reset
// sequences, then random traffic against a behavioural model of the block.
module tb_moving_block_renderer;

  localparam int HALF_W = 150, HALF_H = 90, STEP = 2;
  localparam int LX = 144 + HALF_W, HX = 783 - HALF_W, LY = 35 + HALF_H, HY = 514 - HALF_H;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        bright = 1'b0;
  logic [9:0]  hCount = 10'd5;
  logic [9:0]  vCount = 10'd5;
  logic        mode = 1'b0;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic [11:0] rgb, rgb3;
  logic [9:0]  xpos, ypos, xpos3, ypos3;
  logic        move_tick, tick3;

  int n_cmp = 0;
  int n_bad = 0;
  int ticks = 0;
  int ticks3 = 0;

  always #5 clk = ~clk;

  moving_block_renderer dut (
    .clk(clk), .rst(rst), .bright(bright), .hCount(hCount), .vCount(vCount), .mode(mode),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .rgb(rgb), .xpos(xpos), .ypos(ypos), .move_tick(move_tick)
  );

  // Second instance: slow divider and a start point next to the limits.
  moving_block_renderer #(.FRAME_DIV(3), .X_INIT(630), .Y_INIT(423)) dut3 (
    .clk(clk), .rst(rst), .bright(bright), .hCount(hCount), .vCount(vCount), .mode(mode),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .rgb(rgb3), .xpos(xpos3), .ypos(ypos3), .move_tick(tick3)
  );

  // Behavioural model of the default instance, plain integer arithmetic.
  int m_x, m_y, m_dx, m_dy, m_fc, m_tick, m_rgb, m_prev00;
  always @(posedge clk) begin
    automatic int at00 = (hCount == 0 && vCount == 0) ? 1 : 0;
    automatic int nx = m_x, ny = m_y, ndx = m_dx, ndy = m_dy;
    automatic int mv = 0;
    if (!rst) begin
      m_x <= 450; m_y <= 250; m_dx <= 1; m_dy <= 1;
      m_fc <= 0; m_tick <= 0; m_rgb <= 0; m_prev00 <= 0;
    end else begin
      if (at00 == 1 && m_prev00 == 0) mv = 1;  // FRAME_DIV == 1: every new frame moves
      m_prev00 <= at00;
      m_tick   <= mv;
      if (mv == 1) begin
        if (mode) begin
          nx = m_x + (m_dx == 1 ? STEP : -STEP);
          if (nx > HX) begin nx = HX; ndx = 0; end
          else if (nx < LX) begin nx = LX; ndx = 1; end
          ny = m_y + (m_dy == 1 ? STEP : -STEP);
          if (ny > HY) begin ny = HY; ndy = 0; end
          else if (ny < LY) begin ny = LY; ndy = 1; end
        end else begin
          nx = m_x + STEP * (int'(btn_right) - int'(btn_left));
          ny = m_y + STEP * (int'(btn_down) - int'(btn_up));
          nx = (nx > HX) ? HX : (nx < LX) ? LX : nx;
          ny = (ny > HY) ? HY : (ny < LY) ? LY : ny;
        end
      end
      m_x <= nx; m_y <= ny; m_dx <= ndx; m_dy <= ndy;
      if (!bright) m_rgb <= 0;
      else if ((int'(hCount) - m_x) <= HALF_W && (m_x - int'(hCount)) <= HALF_W &&
               (int'(vCount) - m_y) <= HALF_H && (m_y - int'(vCount)) <= HALF_H)
        m_rgb <= 'h0F0;
      else m_rgb <= 'hFFF;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (move_tick) ticks++;
    if (tick3) ticks3++;
  endtask

  task automatic frame();
    hCount = 10'd0; vCount = 10'd0;
    step(); step();
    hCount = 10'd5; vCount = 10'd5;
    step(); step();
  endtask

  typedef struct {
    logic        b;
    logic [9:0]  h;
    logic [9:0]  v;
    logic [11:0] exp;
  } rvec_t;

  rvec_t tbl[10];

  initial begin
    tbl[0] = '{1'b1, 10'd300, 10'd160, 12'h0F0};
    tbl[1] = '{1'b1, 10'd299, 10'd250, 12'hFFF};
    tbl[2] = '{1'b0, 10'd300, 10'd160, 12'h000};
    tbl[3] = '{1'b1, 10'd450, 10'd250, 12'h0F0};
    tbl[4] = '{1'b1, 10'd600, 10'd340, 12'h0F0};
    tbl[5] = '{1'b1, 10'd601, 10'd250, 12'hFFF};
    tbl[6] = '{1'b1, 10'd450, 10'd341, 12'hFFF};
    tbl[7] = '{1'b1, 10'd450, 10'd159, 12'hFFF};
    tbl[8] = '{1'b1, 10'd783, 10'd514, 12'hFFF};
    tbl[9] = '{1'b0, 10'd450, 10'd250, 12'h000};

    // Reset
    repeat (3) step();
    chk("reset_xpos", xpos, 450);
    chk("reset_ypos", ypos, 250);
    chk("reset_rgb", rgb, 0);
    chk("reset_tick", move_tick, 0);
    chk("reset_xpos3", xpos3, 630);
    rst = 1'b1;

    // Render table
    foreach (tbl[i]) begin
      bright = tbl[i].b; hCount = tbl[i].h; vCount = tbl[i].v;
      step();
      chk($sformatf("render_%0d", i), rgb, tbl[i].exp);
    end
    bright = 1'b0; hCount = 10'd5; vCount = 10'd5;

    // Start-of-frame detection over a 4-clk (0,0)
    ticks = 0; ticks3 = 0;
    hCount = 10'd0; vCount = 10'd0;
    repeat (4) step();
    hCount = 10'd5; vCount = 10'd5;
    repeat (2) step();
    chk("sof_single_pulse", ticks, 1);
    chk("sof_div3_none_yet", ticks3, 0);
    ticks = 0;
    repeat (6) frame();
    chk("div1_six_frames", ticks, 6);
    chk("div3_six_frames", ticks3, 2);
    chk("manual_idle_hold", xpos, 450);

    // Manual clamp at HX
    btn_right = 1'b1;
    repeat (91) frame();
    chk("clamp_632", xpos, 632);
    frame();
    chk("clamp_633", xpos, 633);
    frame();
    chk("clamp_hold", xpos, 633);
    btn_left = 1'b1;
    frame();
    chk("both_btn_hold", xpos, 633);
    chk("manual_y_hold", ypos, 250);
    btn_left = 1'b0; btn_right = 1'b0;

    // Bounce (slow instance starts at x=630, y=423)
    rst = 1'b0; step(); rst = 1'b1;
    mode = 1'b1;
    repeat (3) frame();
    chk("bounce_y_clip", ypos3, 424);
    chk("bounce_x_land", xpos3, 632);
    repeat (3) frame();
    chk("bounce_y_back", ypos3, 422);
    chk("bounce_x_clip", xpos3, 633);
    repeat (3) frame();
    chk("bounce_x_back", xpos3, 631);
    chk("auto_main_x", xpos, 450 + 9 * STEP);
    chk("auto_main_y", ypos, 250 + 9 * STEP);

    // Reset mid-motion on a visible line
    bright = 1'b1; hCount = 10'd300; vCount = 10'd160;
    step();
    chk("pre_reset_rgb", rgb, 'hFFF);
    rst = 1'b0;
    step();
    chk("midreset_xpos", xpos, 450);
    chk("midreset_rgb", rgb, 0);
    rst = 1'b1;
    step();
    chk("post_reset_rgb", rgb, 'h0F0);

    // Randomised traffic against the model
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        hCount = 10'd0; vCount = 10'd0;
      end else begin
        hCount = 10'($urandom_range(0, 799));
        vCount = 10'($urandom_range(0, 524));
      end
      bright = 1'($urandom);
      {btn_up, btn_down, btn_left, btn_right} = 4'($urandom);
      if ($urandom_range(0, 99) == 0) mode = ~mode;
      rst = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      step();
      chk("rand_xpos", xpos, m_x);
      chk("rand_ypos", ypos, m_y);
      chk("rand_rgb", rgb, m_rgb);
      chk("rand_tick", move_tick, m_tick);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
